integer_wb_writer: RTL and testbench

Writeback-side writer for the integer register file. Accepts results from two producers, the single-cycle ALU and the variable-latency load/store unit (LSU), over valid/ready handshakes. LSU results are buffered in a 2-entry FIFO. One write per cycle is arbitrated onto the register file write port (rd_addr, wr_en, rd data). Sits between the execute/memory stages and the write side of integer_file.

---
 rtl/integer_wb_writer.sv | 108 ++++++++++
 tb/tb_integer_wb_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/integer_wb_writer.sv
// rtl/integer_wb_writer.sv - ALU/LSU writeback arbiter with 2-entry LSU FIFO
module integer_wb_writer #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            alu_valid_in,
    output logic            alu_ready_out,
    input  logic [4:0]      alu_rd_addr_in,
    input  logic [XLEN-1:0] alu_data_in,
    input  logic            lsu_valid_in,
    output logic            lsu_ready_out,
    input  logic [4:0]      lsu_rd_addr_in,
    input  logic [XLEN-1:0] lsu_data_in,
    output logic [4:0]      rd_addr_out,
    output logic            wr_en_out,
    output logic [XLEN-1:0] rd_out,
    output logic            busy_out
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]      fifo_addr [2];
    logic [XLEN-1:0] fifo_data [2];
    logic [1:0]      count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [3:0]      starve_cnt;

    logic            force_lsu;
    logic            alu_win;
    logic            lsu_win;
    logic            push;
    logic [4:0]      head_addr;
    logic [XLEN-1:0] head_data;

    // Arbitration: ALU has priority unless a waiting load has been starved too long
    always_comb begin
        force_lsu     = (starve_cnt == LIMIT) && (count != 2'd0);
        alu_ready_out = reset_in && !force_lsu;
        lsu_ready_out = reset_in && (count != 2'd2);
        alu_win       = alu_valid_in && alu_ready_out;
        lsu_win       = !alu_win && (count != 2'd0);
        push          = lsu_valid_in && lsu_ready_out;
        head_addr     = fifo_addr[rd_ptr];
        head_data     = fifo_data[rd_ptr];
        busy_out      = (count != 2'd0);
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_rd_addr_in;
            fifo_data[wr_ptr] <= lsu_data_in;
        end
    end

    // FIFO occupancy and wrapping pointers
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (lsu_win) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, lsu_win})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Count ALU wins while a load waits; saturates so force_lsu stays asserted
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            starve_cnt <= 4'd0;
        end else if (lsu_win || (count == 2'd0)) begin
            starve_cnt <= 4'd0;
        end else if (alu_win && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Registered write port; x0 writes update address/data but never enable
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            wr_en_out   <= 1'b0;
            rd_addr_out <= 5'd0;
            rd_out      <= '0;
        end else if (alu_win) begin
            wr_en_out   <= (alu_rd_addr_in != 5'd0);
            rd_addr_out <= alu_rd_addr_in;
            rd_out      <= alu_data_in;
        end else if (lsu_win) begin
            wr_en_out   <= (head_addr != 5'd0);
            rd_addr_out <= head_addr;
            rd_out      <= head_data;
        end else begin
            wr_en_out   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_integer_wb_writer.sv
// tb/tb_integer_wb_writer.sv - scoreboard testbench for integer_wb_writer
module tb_integer_wb_writer;
    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        alu_valid_in;
    logic        alu_ready_out;
    logic [4:0]  alu_rd_addr_in;
    logic [31:0] alu_data_in;
    logic        lsu_valid_in;
    logic        lsu_ready_out;
    logic [4:0]  lsu_rd_addr_in;
    logic [31:0] lsu_data_in;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic [31:0] rd_out;
    logic        busy_out;

    integer_wb_writer #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_rd_addr_in (alu_rd_addr_in),
        .alu_data_in    (alu_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_addr_in (lsu_rd_addr_in),
        .lsu_data_in    (lsu_data_in),
        .rd_addr_out    (rd_addr_out),
        .wr_en_out      (wr_en_out),
        .rd_out         (rd_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          stamp;
    } ent_t;

    ent_t alu_q[$];
    ent_t lsu_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic        a_acc, l_acc;
    logic        s_alu_ready, s_lsu_ready, s_wr_en, s_busy;
    logic [4:0]  s_rd_addr;
    logic [31:0] s_rd;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; records acceptance and pushes expected writes
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        ent_t e;
        alu_valid_in = av; alu_rd_addr_in = aa; alu_data_in = ad;
        lsu_valid_in = lv; lsu_rd_addr_in = la; lsu_data_in = ld;
        @(negedge clk_in);
        s_alu_ready = alu_ready_out; s_lsu_ready = lsu_ready_out;
        s_wr_en = wr_en_out; s_busy = busy_out; s_rd_addr = rd_addr_out; s_rd = rd_out;
        a_acc = av && alu_ready_out;
        l_acc = lv && lsu_ready_out;
        if (a_acc && aa != 5'd0) begin
            e.addr = aa; e.data = ad; e.stamp = cyc; alu_q.push_back(e);
        end
        if (l_acc && la != 5'd0) begin
            e.addr = la; e.data = ld; e.stamp = cyc; lsu_q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        alu_valid_in = 1'b0;
        lsu_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: every enabled write must match the oldest pending ALU or LSU result
    always @(negedge clk_in) begin
        if (wr_en_out === 1'b1) begin
            checks++;
            if (alu_q.size() > 0 && alu_q[0].addr == rd_addr_out && alu_q[0].data == rd_out) begin
                if (cyc != alu_q[0].stamp + 1) begin
                    errors++;
                    $display("FAIL alu_latency actual=%0d expected=%0d", cyc - alu_q[0].stamp, 1);
                end
                void'(alu_q.pop_front());
            end else if (lsu_q.size() > 0 && lsu_q[0].addr == rd_addr_out && lsu_q[0].data == rd_out) begin
                if (cyc < lsu_q[0].stamp + 2) begin
                    errors++;
                    $display("FAIL lsu_latency actual=%0d expected>=%0d", cyc - lsu_q[0].stamp, 2);
                end
                void'(lsu_q.pop_front());
            end else begin
                errors++;
                $display("FAIL write actual=x%0d:%0h expected=alu x%0d:%0h or lsu x%0d:%0h",
                         rd_addr_out, rd_out,
                         alu_q.size() > 0 ? alu_q[0].addr : 5'd0, alu_q.size() > 0 ? alu_q[0].data : 32'd0,
                         lsu_q.size() > 0 ? lsu_q[0].addr : 5'd0, lsu_q.size() > 0 ? lsu_q[0].data : 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int li;
        int aseq;
        logic [4:0]  laddr [3];
        logic [31:0] ldata [3];

        reset_in = 1'b0;
        alu_valid_in = 1'b0; alu_rd_addr_in = 5'd0; alu_data_in = 32'd0;
        lsu_valid_in = 1'b0; lsu_rd_addr_in = 5'd0; lsu_data_in = 32'd0;

        // Reset held low for two cycles
        idle(2);
        chk("rst_wr_en", s_wr_en, 0);
        chk("rst_rd_addr", s_rd_addr, 0);
        chk("rst_rd", s_rd, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_alu_ready", s_alu_ready, 0);
        chk("rst_lsu_ready", s_lsu_ready, 0);
        reset_in = 1'b1;

        // ALU write x10
        step(1'b1, 5'd10, 32'hABCDEF01, 1'b0, 5'd0, 32'd0);
        chk("alu_accept", a_acc, 1);
        idle(1);
        chk("alu_wr_en", s_wr_en, 1);
        chk("alu_rd_addr", s_rd_addr, 10);
        chk("alu_rd", s_rd, 32'hABCDEF01);

        // x0 suppression, ALU then LSU
        step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
        chk("x0_alu_ready", s_alu_ready, 1);
        idle(1);
        chk("x0_alu_wr_en", s_wr_en, 0);
        chk("x0_alu_rd_addr", s_rd_addr, 0);
        chk("x0_alu_rd", s_rd, 32'h12345678);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD0000);
        chk("x0_lsu_accept", l_acc, 1);
        idle(1);
        chk("x0_lsu_busy", s_busy, 1);
        idle(1);
        chk("x0_lsu_busy_clear", s_busy, 0);
        chk("x0_lsu_wr_en", s_wr_en, 0);
        chk("x0_lsu_rd", s_rd, 32'hDEAD0000);

        // FIFO full / backpressure under continuous ALU traffic
        laddr[0] = 5'd3; ldata[0] = 32'h3;
        laddr[1] = 5'd4; ldata[1] = 32'h4;
        laddr[2] = 5'd5; ldata[2] = 32'h5;
        li = 0; aseq = 0;
        for (int i = 0; i < 40 && li < 3; i++) begin
            step(1'b1, 5'(8 + aseq % 8), 32'hA000 + 32'(aseq), 1'b1, laddr[li], ldata[li]);
            if (i == 2) begin
                chk("full_lsu_ready", s_lsu_ready, 0);
                chk("full_third_held", l_acc, 0);
            end
            if (a_acc) aseq++;
            if (l_acc) li++;
        end
        chk("full_all_pushed", li, 3);
        idle(8);
        chk("full_drained", s_busy, 0);

        // Starvation with STARVE_LIMIT=4
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 5'd9, 32'hB000 + 32'(aseq), 1'b0, 5'd0, 32'd0);
            if (k < 4) chk("starve_alu_win", a_acc, 1);
            if (k == 4) chk("starve_alu_ready_low", s_alu_ready, 0);
            if (k == 5) begin
                chk("starve_x7_wr_en", s_wr_en, 1);
                chk("starve_x7_addr", s_rd_addr, 7);
                chk("starve_x7_data", s_rd, 32'h77);
                chk("starve_alu_ready_back", s_alu_ready, 1);
            end
            if (a_acc) aseq++;
        end
        idle(2);

        // Simultaneous push/pop at count 1 across pointer wraps
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + j), 32'hC000 + 32'(j));
            chk("pp_accept", l_acc, 1);
            if (j > 0) chk("pp_busy", s_busy, 1);
        end
        idle(3);
        chk("pp_drained", s_busy, 0);

        // Reset mid-operation with FIFO full
        step(1'b1, 5'd11, 32'hE1, 1'b1, 5'd12, 32'hD0);
        step(1'b1, 5'd11, 32'hE2, 1'b1, 5'd13, 32'hD1);
        chk("mr_fill", l_acc, 1);
        reset_in = 1'b0;
        idle(1);
        chk("mr_alu_ready", s_alu_ready, 0);
        chk("mr_lsu_ready", s_lsu_ready, 0);
        lsu_q.delete();
        reset_in = 1'b1;
        idle(1);
        chk("mr_busy", s_busy, 0);
        chk("mr_wr_en", s_wr_en, 0);
        idle(6);

        chk("alu_q_empty", alu_q.size(), 0);
        chk("lsu_q_empty", lsu_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
